// File: rtl/serial_ram_frame_buffer.sv
// Serial-in sample buffer with auto-incrementing write pointer, registered random-access
// read port, frame restart, fill tracking and full/overflow status.
module serial_ram_frame_buffer #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 6,
    parameter int WRAP_MODE     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     data_in_valid,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0]    data,
    output logic [ADDRESS_WIDTH-1:0] wr_ptr,
    output logic [ADDRESS_WIDTH:0]   fill_count,
    output logic                     full,
    output logic                     overflow,
    output logic                     frame_done
);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    localparam int                   DEPTH   = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_C = (ADDRESS_WIDTH+1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH:0] LAST_C  = (ADDRESS_WIDTH+1)'(DEPTH - 1);
    localparam logic                 WRAP_C  = (WRAP_MODE != 0);

    logic [DATA_WIDTH-1:0]    mem_r [DEPTH];
    logic [1:0]               state_r;
    logic [ADDRESS_WIDTH-1:0] wr_ptr_r;
    logic [ADDRESS_WIDTH:0]   fill_count_r;
    logic                     full_r;
    logic                     overflow_r;
    logic                     frame_done_r;
    logic [DATA_WIDTH-1:0]    data_r;

    logic [1:0]               base_state_s;
    logic [ADDRESS_WIDTH-1:0] base_ptr_s;
    logic [ADDRESS_WIDTH:0]   base_count_s;
    logic                     base_overflow_s;
    logic                     accept_s;
    logic                     ovf_event_s;
    logic [1:0]               state_nxt_s;
    logic [ADDRESS_WIDTH-1:0] wr_ptr_nxt_s;
    logic [ADDRESS_WIDTH:0]   fill_count_nxt_s;
    logic                     overflow_nxt_s;
    logic                     frame_done_nxt_s;
    logic                     full_nxt_s;

    // Next-state logic: a restart is applied first so a same-cycle sample lands at address 0
    always_comb begin
        base_state_s     = state_r;
        base_ptr_s       = wr_ptr_r;
        base_count_s     = fill_count_r;
        base_overflow_s  = overflow_r;
        accept_s         = 1'b0;
        ovf_event_s      = 1'b0;
        state_nxt_s      = ST_EMPTY;
        wr_ptr_nxt_s     = wr_ptr_r;
        fill_count_nxt_s = fill_count_r;
        overflow_nxt_s   = overflow_r;
        frame_done_nxt_s = 1'b0;
        full_nxt_s       = 1'b0;

        if (frame_start) begin
            base_state_s    = ST_EMPTY;
            base_ptr_s      = {ADDRESS_WIDTH{1'b0}};
            base_count_s    = {(ADDRESS_WIDTH+1){1'b0}};
            base_overflow_s = 1'b0;
        end else begin
            base_state_s    = state_r;
            base_ptr_s      = wr_ptr_r;
            base_count_s    = fill_count_r;
            base_overflow_s = overflow_r;
        end

        if (data_in_valid) begin
            case (base_state_s)
                ST_EMPTY, ST_FILLING: begin
                    accept_s    = 1'b1;
                    ovf_event_s = 1'b0;
                end
                ST_FULL: begin
                    accept_s    = WRAP_C;
                    ovf_event_s = 1'b1;
                end
                default: begin
                    accept_s    = 1'b0;
                    ovf_event_s = 1'b0;
                end
            endcase
        end else begin
            accept_s    = 1'b0;
            ovf_event_s = 1'b0;
        end

        if (accept_s) begin
            wr_ptr_nxt_s = base_ptr_s + ADDRESS_WIDTH'(1);
        end else begin
            wr_ptr_nxt_s = base_ptr_s;
        end

        // Count saturates at DEPTH, so frame_done can only fire once per frame
        if (accept_s && (base_count_s != DEPTH_C)) begin
            fill_count_nxt_s = base_count_s + (ADDRESS_WIDTH+1)'(1);
            frame_done_nxt_s = (base_count_s == LAST_C);
        end else begin
            fill_count_nxt_s = base_count_s;
            frame_done_nxt_s = 1'b0;
        end

        overflow_nxt_s = base_overflow_s | ovf_event_s;
        full_nxt_s     = (fill_count_nxt_s == DEPTH_C);

        if (full_nxt_s) begin
            state_nxt_s = ST_FULL;
        end else if (fill_count_nxt_s == {(ADDRESS_WIDTH+1){1'b0}}) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            state_nxt_s = ST_FILLING;
        end
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_EMPTY;
            wr_ptr_r     <= {ADDRESS_WIDTH{1'b0}};
            fill_count_r <= {(ADDRESS_WIDTH+1){1'b0}};
            full_r       <= 1'b0;
            overflow_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            wr_ptr_r     <= wr_ptr_nxt_s;
            fill_count_r <= fill_count_nxt_s;
            full_r       <= full_nxt_s;
            overflow_r   <= overflow_nxt_s;
            frame_done_r <= frame_done_nxt_s;
        end
    end

    // Sample storage write port (no reset on the array)
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[base_ptr_s] <= data_in;
        end
    end

    // Registered read port; old content is returned on a same-address write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            data_r <= mem_r[addr];
        end
    end

    assign data       = data_r;
    assign wr_ptr     = wr_ptr_r;
    assign fill_count = fill_count_r;
    assign full       = full_r;
    assign overflow   = overflow_r;
    assign frame_done = frame_done_r;

endmodule
